// File: rtl/instr_fetch.sv
// Fetch stage of the X9 core: program counter, next-PC selection
// (increment / branch through a 16-entry target LUT / hold), opcode slicing
// for the control decoder, and a run/halt FSM with a saturating run-cycle counter.
module instr_fetch #(
   parameter int PCW       = 10,
   parameter int IW        = 9,
   parameter int MCODEBITS = 5,
   parameter int CNTW      = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [PCW-1:0]       StartAddr,
   input  logic [IW-1:0]        InstrData,
   input  logic                 Branch,
   input  logic                 Taken,
   input  logic                 Stall,
   input  logic                 LutWe,
   input  logic [3:0]           LutAddr,
   input  logic [PCW-1:0]       LutData,
   output logic [PCW-1:0]       InstrAddr,
   output logic [MCODEBITS-1:0] Opcode,
   output logic                 Running,
   output logic                 Done,
   output logic [CNTW-1:0]      CycleCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [PCW-1:0]  pc, pc_nxt;
   logic [CNTW-1:0] cnt, cnt_nxt;
   logic [PCW-1:0]  lut [16];
   logic            halt;
   logic            lut_wen;

   // The all-ones instruction word is the halt marker.
   assign halt    = (InstrData == '1);
   // Target table is only writable while no program is executing.
   assign lut_wen = LutWe && (state != RUN);

   // Next-state, next-PC and counter selection.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (that would infer a latch).
      state_nxt = state;
      pc_nxt    = pc;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE, DONE: begin
            if (Start) begin
               state_nxt = RUN;
               pc_nxt    = StartAddr;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (cnt != '1) begin
               cnt_nxt = cnt + 1'b1;
            end
            if (halt) begin
               state_nxt = DONE;
            end else if (Stall) begin
               pc_nxt = pc;
            end else if (Branch && Taken) begin
               pc_nxt = lut[InstrData[3:0]];
            end else begin
               pc_nxt = pc + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, PC and run-cycle counter registers.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
      if (Reset) begin
         state <= IDLE;
         pc    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Branch-target table; written only outside RUN.
   always_ff @(posedge Clk) begin
      // NOTE: this small register-file table is reset because branches after reset must resolve to address 0.
      if (Reset) begin
         for (int i = 0; i < 16; i++) begin
            lut[i] <= '0;
         end
      end else if (lut_wen) begin
         lut[LutAddr] <= LutData;
      end
   end

   assign InstrAddr  = pc;
   assign Opcode     = InstrData[IW-1 -: MCODEBITS];
   assign Running    = (state == RUN);
   assign Done       = (state == DONE);
   assign CycleCount = cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a behavioural ROM and branch map drive
// the fetch stage; expected PC/counter sequences are queued and compared per cycle.
module tb_instr_fetch;

   localparam int PCW       = 10;
   localparam int IW        = 9;
   localparam int MCODEBITS = 5;
   localparam int CNTW      = 16;

   logic                 Clk = 1'b0;
   logic                 Reset, Start, Branch, Taken, Stall, LutWe;
   logic [PCW-1:0]       StartAddr, LutData;
   logic [3:0]           LutAddr;
   logic [IW-1:0]        InstrData;
   logic [PCW-1:0]       InstrAddr;
   logic [MCODEBITS-1:0] Opcode;
   logic                 Running, Done;
   logic [CNTW-1:0]      CycleCount;

   logic [IW-1:0] rom    [1024];
   logic          br_mem [1024];

   assign InstrData = rom[InstrAddr];
   assign Branch    = br_mem[InstrAddr];

   always #5 Clk = ~Clk;

   instr_fetch #(.PCW(PCW), .IW(IW), .MCODEBITS(MCODEBITS), .CNTW(CNTW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
      .InstrData(InstrData), .Branch(Branch), .Taken(Taken), .Stall(Stall),
      .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
      .InstrAddr(InstrAddr), .Opcode(Opcode), .Running(Running), .Done(Done),
      .CycleCount(CycleCount)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [PCW-1:0]  addr;
      logic [CNTW-1:0] cnt;
      logic            chk_cnt;
      logic            stall;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [IW-1:0]        instr;
      logic [MCODEBITS-1:0] opc;
   } opc_vec_t;

   typedef struct {
      logic           taken;
      logic           lut_with_start;
      logic [PCW-1:0] exp_after_branch;
   } br_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1; Start = 1'b0; LutWe = 1'b0; Stall = 1'b0; Taken = 1'b0;
      tick();
      Reset = 1'b0;
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 1024; i++) begin
         rom[i]    = '0;
         br_mem[i] = 1'b0;
      end
      #1;
   endtask

   task automatic start_prog(input logic [PCW-1:0] addr);
      Start = 1'b1; StartAddr = addr;
      tick();
      Start = 1'b0;
   endtask

   task automatic push(input logic [PCW-1:0] addr, input logic [CNTW-1:0] cnt,
                       input logic chk_cnt, input logic stall);
      exp_t e;
      e.addr = addr; e.cnt = cnt; e.chk_cnt = chk_cnt; e.stall = stall;
      sb_q.push_back(e);
   endtask

   // Compare one queued expectation per cycle; no clock edge after the last one.
   task automatic drain(input string tag);
      int n;
      exp_t e;
      n = sb_q.size();
      for (int i = 0; i < n; i++) begin
         e = sb_q.pop_front();
         check({tag, " addr"}, 32'(InstrAddr), 32'(e.addr));
         if (e.chk_cnt) check({tag, " cnt"}, 32'(CycleCount), 32'(e.cnt));
         Stall = e.stall;
         if (i != n - 1) tick();
      end
   endtask

   opc_vec_t opc_tab [5];
   br_vec_t  br_tab  [2];

   initial begin
      opc_tab[0] = '{instr: 9'h1FF, opc: 5'h1F};
      opc_tab[1] = '{instr: 9'h000, opc: 5'h00};
      opc_tab[2] = '{instr: 9'h150, opc: 5'h15};
      opc_tab[3] = '{instr: 9'h0AB, opc: 5'h0A};
      opc_tab[4] = '{instr: 9'h10F, opc: 5'h10};
      br_tab[0]  = '{taken: 1'b1, lut_with_start: 1'b1, exp_after_branch: 10'd100};
      br_tab[1]  = '{taken: 1'b0, lut_with_start: 1'b0, exp_after_branch: 10'd3};

      Reset = 1'b1; Start = 1'b0; StartAddr = '0; Taken = 1'b0; Stall = 1'b0;
      LutWe = 1'b0; LutAddr = '0; LutData = '0;
      rom_clear();

      // Reset state.
      do_reset();
      check("rst addr", 32'(InstrAddr), 32'd0);
      check("rst running", 32'(Running), 32'd0);
      check("rst done", 32'(Done), 32'd0);
      check("rst cnt", 32'(CycleCount), 32'd0);

      // Opcode slicing, combinational from the ROM word at PC 0.
      for (int i = 0; i < 5; i++) begin
         rom[0] = opc_tab[i].instr;
         #1;
         check("opcode", 32'(Opcode), 32'(opc_tab[i].opc));
      end

      // Straight-line program ending in halt at address 4.
      rom_clear();
      rom[4] = 9'h1FF;
      start_prog(10'd0);
      check("t1 running", 32'(Running), 32'd1);
      for (int i = 0; i < 5; i++) push(PCW'(i), CNTW'(i), 1'b1, 1'b0);
      drain("t1");
      tick();
      check("t1 done", 32'(Done), 32'd1);
      check("t1 running off", 32'(Running), 32'd0);
      check("t1 halt addr", 32'(InstrAddr), 32'd4);
      check("t1 cnt", 32'(CycleCount), 32'd5);
      tick();
      check("t1 hold addr", 32'(InstrAddr), 32'd4);
      check("t1 hold cnt", 32'(CycleCount), 32'd5);

      // Branch through LUT[3], taken and not taken.
      for (int v = 0; v < 2; v++) begin
         do_reset();
         rom_clear();
         rom[2] = 9'h003; br_mem[2] = 1'b1;
         Taken = br_tab[v].taken;
         LutWe = 1'b1; LutAddr = 4'd3; LutData = 10'd100;
         if (!br_tab[v].lut_with_start) begin
            tick();
            LutWe = 1'b0;
         end
         start_prog(10'd0);
         LutWe = 1'b0;
         push(10'd0, '0, 1'b0, 1'b0);
         push(10'd1, '0, 1'b0, 1'b0);
         push(10'd2, '0, 1'b0, 1'b0);
         push(br_tab[v].exp_after_branch, '0, 1'b0, 1'b0);
         drain("t2 branch");
      end

      // Two-cycle stall at PC 5; counter keeps running.
      do_reset();
      rom_clear();
      start_prog(10'd5);
      push(10'd5, 16'd0, 1'b1, 1'b1);
      push(10'd5, 16'd1, 1'b1, 1'b1);
      push(10'd5, 16'd2, 1'b1, 1'b0);
      push(10'd6, 16'd3, 1'b1, 1'b0);
      drain("t3 stall");

      // PC wrap, LUT write and Start ignored during RUN, then halt with everything asserted.
      do_reset();
      rom_clear();
      rom[2] = 9'h003; br_mem[2] = 1'b1;
      rom[100] = 9'h1FF; br_mem[100] = 1'b1;
      LutWe = 1'b1; LutAddr = 4'd3; LutData = 10'd100;
      tick();
      LutWe = 1'b0;
      start_prog(10'd1023);
      Taken = 1'b1;
      LutWe = 1'b1; LutData = 10'd200;
      Start = 1'b1; StartAddr = 10'd50;
      push(10'd1023, 16'd0, 1'b1, 1'b0);
      push(10'd0, 16'd1, 1'b1, 1'b0);
      push(10'd1, 16'd2, 1'b1, 1'b0);
      push(10'd2, 16'd3, 1'b1, 1'b0);
      push(10'd100, 16'd4, 1'b1, 1'b1);
      drain("t4 wrap");
      Start = 1'b0; LutWe = 1'b0;
      tick();
      check("t5 done", 32'(Done), 32'd1);
      check("t5 halt addr", 32'(InstrAddr), 32'd100);
      check("t5 cnt", 32'(CycleCount), 32'd5);
      tick();
      check("t5 stall in done", 32'(InstrAddr), 32'd100);
      Stall = 1'b0;
      start_prog(10'd50);
      check("t5 restart addr", 32'(InstrAddr), 32'd50);
      check("t5 restart cnt", 32'(CycleCount), 32'd0);
      check("t5 restart running", 32'(Running), 32'd1);
      check("t5 restart done", 32'(Done), 32'd0);

      // Reset mid-RUN at PC 7 while a branch is presented, then LUT reads back 0.
      do_reset();
      rom_clear();
      LutWe = 1'b1; LutAddr = 4'd3; LutData = 10'd100;
      tick();
      LutWe = 1'b0;
      rom[2] = 9'h003; br_mem[2] = 1'b1;
      rom[7] = 9'h003; br_mem[7] = 1'b1;
      #1;
      Taken = 1'b1;
      start_prog(10'd5);
      push(10'd5, 16'd0, 1'b1, 1'b0);
      push(10'd6, 16'd1, 1'b1, 1'b0);
      push(10'd7, 16'd2, 1'b1, 1'b0);
      drain("t6 pre");
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("t6 rst addr", 32'(InstrAddr), 32'd0);
      check("t6 rst running", 32'(Running), 32'd0);
      check("t6 rst done", 32'(Done), 32'd0);
      check("t6 rst cnt", 32'(CycleCount), 32'd0);
      start_prog(10'd0);
      push(10'd0, '0, 1'b0, 1'b0);
      push(10'd1, '0, 1'b0, 1'b0);
      push(10'd2, '0, 1'b0, 1'b0);
      push(10'd0, '0, 1'b0, 1'b0);
      drain("t6 lut cleared");

      // Counter saturation over a long halt-free run.
      do_reset();
      rom_clear();
      start_prog(10'd0);
      repeat (65540) tick();
      check("sat cnt", 32'(CycleCount), 32'hFFFF);
      check("sat running", 32'(Running), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and fetch stage of the X9 core, directly upstream of the control decoder. Holds the PC, drives the instruction-memory address, slices the 5-bit opcode out of the returned 9-bit instruction for the decoder, and selects the next PC: increment, branch target from an internal 16-entry target LUT, or hold. A small run/halt state machine and a run-cycle counter frame each program execution for the testbench.

## Interface
- PCW, 10: program counter / instruction address width.
- IW, 9: instruction word width.
- MCODEBITS, 5: opcode width delivered to the control decoder.
- CNTW, 16: run-cycle counter width.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin execution at StartAddr; honored only in IDLE or DONE.
- StartAddr  in  PCW  first instruction address.
- InstrData  in  IW  instruction word from combinational instruction ROM at InstrAddr.
- Branch  in  1  from control decoder: current instruction is a branch.
- Taken  in  1  from ALU: branch condition true.
- Stall  in  1  hold PC this cycle.
- LutWe  in  1  target-LUT write enable.
- LutAddr  in  4  target-LUT write index.
- LutData  in  PCW  target-LUT write data.
- InstrAddr  out  PCW  current PC.
- Opcode  out  MCODEBITS  InstrData[IW-1:IW-MCODEBITS], to control decoder.
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.
- CycleCount  out  CNTW  RUN cycles elapsed in current program.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: PC holds; Start -> RUN, PC <= StartAddr, CycleCount <= 0.
- RUN, priority order per cycle:
  - InstrData == all-ones (9'h1FF, halt) -> DONE; PC holds; halt beats Branch, Taken and Stall.
  - Stall -> PC holds.
  - Branch && Taken -> PC <= Lut[InstrData[3:0]].
  - else PC <= PC + 1, modulo 2^PCW (PC max wraps to 0, no flag).
  - CycleCount increments every RUN cycle including halt cycle and stalled cycles; saturates at 2^CNTW-1.
- DONE: PC and CycleCount hold; Start -> RUN at StartAddr, CycleCount <= 0.
- Start in RUN ignored.
- Target LUT: 16 x PCW registers; write on edge when LutWe and state is IDLE or DONE; writes during RUN ignored. Start and LutWe in same cycle: both take effect at that edge, so first branch of the program sees the new entry.
- Branch with Taken low: plain increment. Taken without Branch: ignored.
- Opcode is combinational from InstrData; InstrAddr is the PC register directly.

## Timing
- Reset (synchronous, one edge): state IDLE, PC 0, all LUT entries 0, CycleCount 0, Running 0, Done 0; InstrAddr 0.
- Reset mid-RUN: next edge back to IDLE with reset values; no further PC update from that cycle's inputs.
- Running/Done are registered state decodes: Running rises the cycle after the Start edge; Done rises the cycle after halt is fetched.
- Fetch latency: ROM is combinational, so InstrData for PC is valid the same cycle; next PC takes effect one edge later. Branch resolution zero extra cycles (no delay slot).
- Stall in IDLE/DONE has no effect.

## Test plan
- Reset then Start, StartAddr=0, ROM words 0..3 non-branch, word 4 = 9'h1FF -> InstrAddr 0,1,2,3,4 on successive cycles, Done high cycle after addr 4, PC stays 4, CycleCount = 5.
- In IDLE write Lut[3]=100; ROM[2] low nibble 3 with Branch=1, Taken=1 -> PC 0,1,2,100; same with Taken=0 -> PC 0,1,2,3.
- Stall asserted 2 cycles at PC=5 -> InstrAddr 5,5,5,6; CycleCount increments through stall.
- PCW=10, StartAddr=1023, ROM[1023] non-branch -> next InstrAddr 0; LutWe during RUN writing Lut[3]=200 -> later branch via index 3 still goes to 100.
- Halt word fetched with Branch=1, Taken=1, Stall=1 -> DONE, PC holds; then Start with StartAddr=50 -> RUN, InstrAddr 50, CycleCount restarts at 0.
- Reset asserted mid-RUN at PC=7 -> next cycle InstrAddr 0, IDLE, Running 0, Done 0, Lut[3] reads back as 0 via branch test.
